// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered integer ALU between two requesters.
// One operation in flight; result is held until the owning requester accepts it.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic [2:0]        req_funct3_0,
  input  logic [2:0]        req_funct3_1,
  input  logic              req_funct7_0,
  input  logic              req_funct7_1,
  input  logic [DATA_W-1:0] req_rs1_0,
  input  logic [DATA_W-1:0] req_rs1_1,
  input  logic [DATA_W-1:0] req_rs2_0,
  input  logic [DATA_W-1:0] req_rs2_1,
  output logic              resp_valid_0,
  output logic              resp_valid_1,
  input  logic              resp_ready_0,
  input  logic              resp_ready_1,
  output logic [DATA_W-1:0] resp_rd_0,
  output logic [DATA_W-1:0] resp_rd_1,
  output logic              resp_z_0,
  output logic              resp_z_1,
  output logic [2:0]        alu_funct3,
  output logic              alu_funct7,
  output logic [DATA_W-1:0] alu_rs1,
  output logic [DATA_W-1:0] alu_rs2,
  input  logic [DATA_W-1:0] alu_rd,
  input  logic              alu_z
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t            state, state_nx;
  logic              owner;
  logic              last_grant;
  logic              grant;
  logic              accept;
  logic              resp_ready_owner;
  logic              z_q;
  logic [DATA_W-1:0] rd_q;

  // NOTE: every signal assigned in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant            = 1'b0;
    accept           = 1'b0;
    state_nx         = state;
    resp_ready_owner = owner ? resp_ready_1 : resp_ready_0;

    // A lone requester always wins; on contention the pointer decides.
    if (req_valid_0 && req_valid_1) grant = ~last_grant;
    else if (req_valid_1)           grant = 1'b1;

    case (state)
      IDLE: begin
        accept = req_valid_0 || req_valid_1;
        if (accept) state_nx = ISSUE;
      end
      ISSUE:   state_nx = CAPT;
      CAPT:    state_nx = RESP;
      RESP:    if (resp_ready_owner) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      alu_funct3 <= '0;
      alu_funct7 <= 1'b0;
      alu_rs1    <= '0;
      alu_rs2    <= '0;
      z_q        <= 1'b0;
      rd_q       <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner      <= grant;
        last_grant <= grant;
        alu_funct3 <= grant ? req_funct3_1 : req_funct3_0;
        alu_funct7 <= grant ? req_funct7_1 : req_funct7_0;
        alu_rs1    <= grant ? req_rs1_1    : req_rs1_0;
        alu_rs2    <= grant ? req_rs2_1    : req_rs2_0;
      end
      // z is combinational on the operands, rd arrives one edge later.
      if (state == ISSUE) z_q  <= alu_z;
      if (state == CAPT)  rd_q <= alu_rd;
    end
  end

  always_comb begin
    req_ready_0  = (state == IDLE) && req_valid_0 && !grant;
    req_ready_1  = (state == IDLE) && req_valid_1 &&  grant;
    resp_valid_0 = (state == RESP) && !owner;
    resp_valid_1 = (state == RESP) &&  owner;
    resp_rd_0    = resp_valid_0 ? rd_q : '0;
    resp_rd_1    = resp_valid_1 ? rd_q : '0;
    resp_z_0     = resp_valid_0 && z_q;
    resp_z_1     = resp_valid_1 && z_q;
  end

endmodule
